// File: rtl/modbus_crc16_arbiter_if.sv
// Bundle between the CRC arbiter, its requesters and the shared CRC engine.
// The arbiter takes the slave view; the requesters and the engine take the master view.
interface modbus_crc16_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_size;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [15:0]             rsp_crc;
    logic                    rsp_err;
    logic                    busy;
    logic                    eng_start;
    logic [7:0]              eng_size;
    logic [SEL_W-1:0]        eng_sel;
    logic                    eng_crc_valid;
    logic [15:0]             eng_crc_data;

    modport slave (
        input  req_valid, req_size, eng_crc_valid, eng_crc_data,
        output rsp_valid, rsp_crc, rsp_err, busy, eng_start, eng_size, eng_sel
    );

    modport master (
        output req_valid, req_size, eng_crc_valid, eng_crc_data,
        input  rsp_valid, rsp_crc, rsp_err, busy, eng_start, eng_size, eng_sel
    );
endinterface

// File: rtl/modbus_crc16_arbiter.sv
// Round-robin sharing of one Modbus CRC16 engine between NUM_REQ requesters.
// All outputs are registered; eng_sel stays fixed from grant until the response.
module modbus_crc16_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int SEL_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                         clk,
    input  logic                         reset_n,
    modbus_crc16_arbiter_if.slave        bus
);
    localparam int IDX_W = SEL_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] NUM_REQ_W = IDX_W'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [15:0]        r_rsp_crc;
    logic               r_rsp_err;
    logic               r_busy;
    logic               r_eng_start;
    logic [7:0]         r_eng_size;
    logic [SEL_W-1:0]   r_eng_sel;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [TMO_W-1:0]   r_tmo;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_rsp_valid_nxt;
    logic [15:0]        w_rsp_crc_nxt;
    logic               w_rsp_err_nxt;
    logic               w_busy_nxt;
    logic               w_eng_start_nxt;
    logic [7:0]         w_eng_size_nxt;
    logic [SEL_W-1:0]   w_eng_sel_nxt;
    logic [SEL_W-1:0]   w_rr_ptr_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;

    logic               w_found;
    logic [SEL_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_timeout;

    // Search upward from rr_ptr; the index sum is below 2*NUM_REQ so one subtraction wraps it.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + IDX_W'(i);
            if (w_idx >= NUM_REQ_W) begin
                w_idx = w_idx - NUM_REQ_W;
            end
            if (!w_found && bus.req_valid[w_idx[SEL_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[SEL_W-1:0];
            end
        end
    end

    assign w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_eng_sel;
    assign w_timeout = (r_tmo == TMO_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = '0;
        w_rsp_crc_nxt   = r_rsp_crc;
        w_rsp_err_nxt   = r_rsp_err;
        w_eng_start_nxt = 1'b0;
        w_eng_size_nxt  = r_eng_size;
        w_eng_sel_nxt   = r_eng_sel;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_tmo_nxt       = r_tmo;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_eng_sel_nxt   = w_winner;
                    w_eng_size_nxt  = bus.req_size[w_winner];
                    w_eng_start_nxt = 1'b1;
                    w_state_nxt     = S_START;
                end
            end
            S_START: begin
                w_tmo_nxt   = '0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                w_tmo_nxt = r_tmo + 1'b1;
                if (w_timeout) begin
                    w_rsp_valid_nxt = w_onehot;
                    w_rsp_crc_nxt   = 16'h0000;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_RESP;
                end else if (!bus.eng_crc_valid) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                w_tmo_nxt = r_tmo + 1'b1;
                if (w_timeout) begin
                    w_rsp_valid_nxt = w_onehot;
                    w_rsp_crc_nxt   = 16'h0000;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_RESP;
                end else if (bus.eng_crc_valid) begin
                    w_rsp_valid_nxt = w_onehot;
                    w_rsp_crc_nxt   = bus.eng_crc_data;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                w_rr_ptr_nxt = (r_eng_sel == SEL_LAST) ? '0 : r_eng_sel + 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= '0;
            r_rsp_crc   <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_size  <= '0;
            r_eng_sel   <= '0;
            r_rr_ptr    <= '0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_crc   <= w_rsp_crc_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_busy      <= w_busy_nxt;
            r_eng_start <= w_eng_start_nxt;
            r_eng_size  <= w_eng_size_nxt;
            r_eng_sel   <= w_eng_sel_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_tmo       <= w_tmo_nxt;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_crc   = r_rsp_crc;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_size  = r_eng_size;
    assign bus.eng_sel   = r_eng_sel;
endmodule

// File: tb/tb_modbus_crc16_arbiter.sv
// Bench for modbus_crc16_arbiter: a behavioural CRC engine reads per-requester byte
// buffers through eng_sel, and a round-robin reference predicts grant, latency and CRC.
module tb_modbus_crc16_arbiter;
    localparam int NREQ = 2;
    localparam int TMO  = 512;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    modbus_crc16_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    modbus_crc16_arbiter #(
        .NUM_REQ(NREQ),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    logic [7:0] mem [NREQ][256];
    logic       stuck = 1'b0;
    logic       e_valid;
    logic       e_busy;
    logic [15:0] e_crc;
    int         e_step;
    int         e_n;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
        end
        return x;
    endfunction

    function automatic logic [15:0] ref_crc(input int r, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) c = crc_byte(c, mem[r][i]);
        return c;
    endfunction

    // Engine model: one idle cycle after start, one byte per cycle, one finishing cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_valid <= 1'b0;
            e_busy  <= 1'b0;
            e_step  <= 0;
            e_n     <= 0;
            e_crc   <= 16'hFFFF;
        end else if (bus.eng_start) begin
            e_valid <= 1'b0;
            e_busy  <= 1'b1;
            e_step  <= 0;
            e_n     <= (bus.eng_size == 8'd0) ? 256 : int'(bus.eng_size);
            e_crc   <= 16'hFFFF;
        end else if (e_busy) begin
            if (e_step >= 1 && e_step <= e_n) e_crc <= crc_byte(e_crc, mem[bus.eng_sel][e_step-1]);
            if (e_step == e_n + 1) begin
                e_busy  <= 1'b0;
                e_valid <= 1'b1;
            end
            e_step <= e_step + 1;
        end
    end

    assign bus.eng_crc_valid = stuck | e_valid;
    assign bus.eng_crc_data  = e_crc;

    function automatic int model_winner();
        int r;
        for (int i = 0; i < NREQ; i++) begin
            r = (model_ptr + i) % NREQ;
            if (bus.req_valid[r]) return r;
        end
        return -1;
    endfunction

    task automatic new_req(input int r, input int size);
        int n;
        n = (size == 0) ? 256 : size;
        for (int i = 0; i < n; i++) mem[r][i] = 8'($urandom);
        bus.req_size[r]  = 8'(size);
        bus.req_valid[r] = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = '0;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Observe one transaction starting from the current requests; after_resp=1 when
    // called at the negedge of the previous RESP cycle (one IDLE cycle precedes the grant).
    task automatic expect_txn(input int after_resp, input bit exp_err, input string tag, output int w);
        int n, lat, k, starts, start_k;
        bit got, sel_bad, busy_bad;
        logic [7:0]  sz;
        logic [1:0]  exp_v;
        logic [15:0] exp_crc;
        w = model_winner();
        if (w < 0) begin
            checks++;
            errors++;
            $display("FAIL %s no_request: got none want one pending", tag);
            w = 0;
            return;
        end
        sz      = bus.req_size[w];
        n       = (sz == 8'd0) ? 256 : int'(sz);
        lat     = (exp_err ? TMO + 2 : n + 5) + after_resp;
        exp_crc = exp_err ? 16'h0000 : ref_crc(w, n);
        exp_v   = 2'b01 << w;
        got = 0; sel_bad = 0; busy_bad = 0; k = 0; starts = 0; start_k = -1;
        while (!got && k < lat + 20) begin
            @(negedge clk);
            k++;
            if (bus.eng_start === 1'b1) begin
                starts++;
                start_k = k;
            end
            if (k >= 1 + after_resp) begin
                if (bus.eng_sel !== 1'(w) || bus.eng_size !== sz) sel_bad = 1;
                if (bus.busy !== 1'b1) busy_bad = 1;
            end else if (bus.busy !== 1'b0) begin
                busy_bad = 1;
            end
            if (bus.rsp_valid !== 2'b00) got = 1;
        end
        checks++;
        if (!got || k != lat) begin
            errors++;
            $display("FAIL %s latency: got cycle %0d (seen=%0d) want cycle %0d", tag, k, got, lat);
        end
        if (got) begin
            checks++;
            if (bus.rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL %s rsp_valid: got %b want %b", tag, bus.rsp_valid, exp_v);
            end
            checks++;
            if (bus.rsp_crc !== exp_crc) begin
                errors++;
                $display("FAIL %s rsp_crc: got %h want %h", tag, bus.rsp_crc, exp_crc);
            end
            checks++;
            if (bus.rsp_err !== exp_err) begin
                errors++;
                $display("FAIL %s rsp_err: got %b want %b", tag, bus.rsp_err, exp_err);
            end
        end
        checks++;
        if (starts != 1 || start_k != 1 + after_resp) begin
            errors++;
            $display("FAIL %s eng_start: got %0d pulses last at %0d want 1 at %0d", tag, starts, start_k, 1 + after_resp);
        end
        checks++;
        if (sel_bad) begin
            errors++;
            $display("FAIL %s eng_sel_stable: got unstable sel/size want sel %0d size %0d", tag, w, sz);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s busy: got wrong busy level want 0 in IDLE and 1 otherwise", tag);
        end
        model_ptr = (w + 1) % NREQ;
    endtask

    task automatic test_reset();
        bit bad;
        int starts;
        bus.req_valid = '0;
        bus.req_size  = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_crc, bus.rsp_err, bus.busy, bus.eng_start, bus.eng_size, bus.eng_sel} !== '0) begin
            errors++;
            $display("FAIL reset_values: got nonzero outputs want all 0");
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0; starts = 0;
        repeat (100) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.rsp_crc, bus.rsp_err, bus.busy, bus.eng_start, bus.eng_size, bus.eng_sel} !== '0) bad = 1;
            if (bus.eng_start !== 1'b0) starts++;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_outputs: got nonzero output while idle want all 0");
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL idle_start: got %0d start pulses want 0", starts);
        end
    endtask

    task automatic test_known_frame();
        int w;
        logic [7:0] frame [6];
        frame = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) mem[0][i] = frame[i];
        bus.req_size[0]  = 8'd6;
        bus.req_valid[0] = 1'b1;
        expect_txn(0, 0, "known_frame", w);
        checks++;
        if (bus.rsp_crc !== 16'h0A84) begin
            errors++;
            $display("FAIL known_crc: got %h want 0a84", bus.rsp_crc);
        end
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_crc !== 16'h0A84) begin
            errors++;
            $display("FAIL crc_hold: got valid %b crc %h want 00 0a84", bus.rsp_valid, bus.rsp_crc);
        end
    endtask

    task automatic test_fair_pair();
        int w;
        do_reset();
        new_req(0, $urandom_range(16, 1));
        new_req(1, $urandom_range(16, 1));
        expect_txn(0, 0, "pair_first", w);
        expect_txn(1, 0, "pair_second", w);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_alternate();
        int w;
        new_req(1, $urandom_range(12, 1));
        new_req(0, $urandom_range(12, 1));
        expect_txn(0, 0, "alt", w);
        for (int i = 0; i < 5; i++) begin
            if (w == 0) new_req(0, $urandom_range(12, 1));
            expect_txn(1, 0, "alt", w);
        end
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_size_256();
        int w;
        new_req(1, 0);
        expect_txn(0, 0, "size_256", w);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int w;
        stuck = 1'b1;
        new_req(0, 5);
        if (model_winner() != 0) model_ptr = 0;
        if (model_ptr != 0) bus.req_valid[1] = 1'b0;
        expect_txn(0, 1, "timeout", w);
        bus.req_valid = '0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        new_req(0, 3);
        new_req(1, 3);
        expect_txn(0, 0, "after_timeout", w);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int w;
        for (int r = 0; r < NREQ; r++) if ($urandom_range(1, 0) == 1) new_req(r, $urandom_range(24, 1));
        if (bus.req_valid == '0) new_req($urandom_range(NREQ - 1, 0), $urandom_range(24, 1));
        expect_txn(0, 0, "random", w);
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(2, 0) == 0) new_req(w, $urandom_range(24, 1));
            else bus.req_valid[w] = 1'b0;
            for (int r = 0; r < NREQ; r++)
                if (r != w && !bus.req_valid[r] && $urandom_range(1, 0) == 1) new_req(r, $urandom_range(24, 1));
            if (bus.req_valid == '0) new_req($urandom_range(NREQ - 1, 0), $urandom_range(24, 1));
            expect_txn(1, 0, "random", w);
        end
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int w;
        bit saw_rsp;
        new_req(0, 20);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_crc, bus.rsp_err, bus.busy, bus.eng_start, bus.eng_size, bus.eng_sel} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got nonzero outputs want all 0");
        end
        saw_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00) saw_rsp = 1;
        end
        bus.req_valid = '0;
        model_ptr = 0;
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00) saw_rsp = 1;
        end
        checks++;
        if (saw_rsp) begin
            errors++;
            $display("FAIL reset_mid_rsp: got a response want none after reset");
        end
        new_req(0, 1);
        expect_txn(0, 0, "after_reset", w);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_known_frame();
        test_fair_pair();
        test_alternate();
        test_size_256();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/modbus_crc16_arbiter.md
Name: modbus_crc16_arbiter

Overview:
- Shares one modbus_crc16_calc engine between NUM_REQ requesters, for example an RX frame checker and a TX frame builder.
- Arbitrates round-robin, loads size into the engine and issues start.
- Holds the data-mux select stable while the engine reads its data bus, then returns the CRC to the winning requester as a one-cycle response.
- Sits between the Modbus RTU framing logic and the CRC engine.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- SEL_W, $clog2(NUM_REQ) (min 1): width of the requester index.
- TIMEOUT_CYCLES, 512: cycle limit for the engine to finish before an error response is returned; must be ≥ 300.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request, level; held until own rsp_valid.
- req_size  in  NUM_REQ x 8  per-requester byte count; 0 means 256 bytes (engine convention).
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_crc  out  16  CRC result, qualified by rsp_valid.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- eng_start  out  1  engine start pulse.
- eng_size  out  8  engine size input.
- eng_sel  out  SEL_W  index of the granted requester; drives the external data mux into the engine.
- eng_crc_valid  in  1  engine crc_valid (level: high while the engine is idle after at least one run).
- eng_crc_data  in  16  engine crc_data.

Behaviour:
- Reset (reset_n low, async assert; deassert is synchronised externally): state=IDLE, rsp_valid=0, rsp_crc=0, rsp_err=0, busy=0, eng_start=0, eng_size=0, eng_sel=0, rr_ptr=0, timeout counter=0. All outputs are registered.
- The engine shares reset_n (inverted). Reset mid-operation abandons the transaction and issues no response; requesters re-request.
- FSM states:
  - IDLE: if any req_valid, pick the first set bit searching from rr_ptr upward with wrap. Register eng_sel=winner and eng_size=req_size[winner], then go to START. Requests arriving in any other state wait.
  - START: eng_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for eng_crc_valid=0, confirming the engine left idle; then go to WAIT_DONE.
  - WAIT_DONE: wait for eng_crc_valid=1. Then capture rsp_crc=eng_crc_data, set rsp_err=0, and go to RESP.
  - RESP: rsp_valid[eng_sel]=1 for one cycle. Set rr_ptr=(eng_sel+1) mod NUM_REQ. Go to IDLE.
- Timeout:
  - The counter increments in WAIT_BUSY and WAIT_DONE.
  - When the counter equals TIMEOUT_CYCLES-1, the next state is RESP with rsp_err=1 and rsp_crc=16'h0000.
  - rr_ptr advances the same way as on a normal response.
- eng_sel and eng_size are constant from IDLE exit through RESP; they change only in IDLE on a new grant.
- rsp_crc and rsp_err hold their last value outside RESP.
- If the granted requester drops req_valid mid-transaction, the transaction still completes and rsp_valid is still pulsed.
- A requester re-asserting in the RESP cycle is seen in the next IDLE cycle. Rotation ensures other pending requesters win first.
- Single-requester back-to-back: at least one IDLE cycle separates RESP and the next START.
- Latency for an engine size of N (1..255):
  - req_valid sampled in IDLE at cycle 0.
  - eng_start at cycle 1.
  - rsp_valid at cycle N+5.
  - Size 0 (256 bytes): rsp_valid at cycle 261.
- Widths: rr_ptr is SEL_W bits, wrapping at NUM_REQ (not at 2^SEL_W). The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

Test Plan:
- Reset, then all req_valid=0 -> busy=0, eng_start never asserts, all outputs 0 for 100 cycles.
- Req0 with size=6 and data 01 03 00 00 00 01 through the real engine -> eng_start pulse at cycle 1, rsp_valid=2'b01 at cycle 11, rsp_crc=eng_crc_data (Modbus CRC 0x0A84, low byte 0x84 sent first), rsp_err=0.
- Req0 and req1 asserted together and held through two transactions, from reset -> req0 served first then req1. rsp_valid pulses 2'b01 then 2'b10; eng_sel is 0 then 1, each stable over its whole transaction.
- Req1 held continuously while req0 pulses repeatedly -> grants strictly alternate 0,1,0,1; neither requester waits more than one transaction.
- Stub engine that holds eng_crc_valid=1 forever -> after TIMEOUT_CYCLES in WAIT_BUSY, rsp_valid with rsp_err=1 and rsp_crc=0, then return to IDLE.
- reset_n asserted during WAIT_DONE -> all outputs 0 immediately (asynchronously), no rsp_valid. A fresh request after release completes normally with size=1 and rsp_valid at cycle 6.
